fmt_num_ascii_stream: RTL and testbench

- Hardware number-to-ASCII formatter. It turns one binary operand into a character stream, following the `$swrite` rules for `%b`, `%o`, `%d` and `%h`.
- It adds parametrised operand width, optional sign, field width, left/right justification, and zero or space padding.
- It sits between a command source (valid/ready) and a character sink such as a UART TX or log FIFO, with one byte per handshake.

---
 rtl/fmt_num_ascii_stream.sv | 231 +++++++++++++++++++++++
 tb/tb_fmt_num_ascii_stream.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fmt_num_ascii_stream.sv
// Formats one binary operand as a bin/oct/dec/hex ASCII field with optional sign,
// minimum width, justification and padding, streamed one byte per handshake.
module fmt_num_ascii_stream #(
    parameter int WIDTH = 32,
    parameter int FW_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic [1:0]       in_mode,
    input  logic             in_signed,
    input  logic             in_plus,
    input  logic [FW_W-1:0]  in_width,
    input  logic             in_left,
    input  logic             in_zpad,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last,
    output logic             busy
);
    localparam int NDEC  = (WIDTH * 3) / 10 + 2;
    localparam int NB    = 4 * NDEC;
    localparam int EXT_W = 4 * WIDTH;
    localparam int CW    = FW_W + 8;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [1:0]    MODE_DEC = 2'b10;
    localparam logic [CW-1:0] C_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_ZERO   = {CW{1'b0}};

    typedef enum logic [1:0] {IDLE = 2'b00, CONV = 2'b01, EMIT = 2'b10} state_t;

    function automatic logic [3:0] digit_of(input logic [EXT_W-1:0] e, input logic [1:0] m, input int k);
        case (m)
            2'b00:   digit_of = 4'(e >> k) & 4'b0001;
            2'b01:   digit_of = 4'(e >> (k * 32'sd3)) & 4'b0111;
            default: digit_of = 4'(e >> (k * 32'sd4));
        endcase
    endfunction

    // Position of the most significant nonzero digit, never less than one digit.
    function automatic logic [CW-1:0] count_digits(input logic [EXT_W-1:0] e, input logic [1:0] m);
        logic [CW-1:0] n;
        n = C_ONE;
        for (int k = 0; k < WIDTH; k++) begin
            if (digit_of(e, m, k) != 4'd0) n = CW'(k + 1);
            else n = n;
        end
        return n;
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        if (d < 4'd10) return 8'h30 + {4'h0, d};
        else return 8'h57 + {4'h0, d};
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   val_q, val_d;
    logic [NB-1:0]      bcd_q, bcd_d, bcd_t;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         sign_q, sign_d;
    logic [FW_W-1:0]    width_q, width_d;
    logic               left_q, left_d, zpad_q, zpad_d;
    logic [CW-1:0]      pos_q, pos_d;
    logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [7:0]         out_char_q, out_char_d;
    logic               in_ready_q, in_ready_d, busy_q, busy_d;

    logic [EXT_W-1:0]   ext_s;
    logic [CW-1:0]      nd_s, len_s, wid_s, total_s, pad_s, p_s, didx_s;
    logic               has_sign_s, last_s;
    logic [7:0]         ch_s;

    // Character and last flag for the position about to be presented (0 when leaving CONV).
    always_comb begin
        ext_s      = (mode_q == MODE_DEC) ? EXT_W'(bcd_q) : EXT_W'(val_q);
        nd_s       = count_digits(ext_s, mode_q);
        has_sign_s = (sign_q != 8'h00);
        len_s      = nd_s + CW'(has_sign_s);
        wid_s      = CW'(width_q);
        total_s    = (wid_s > len_s) ? wid_s : len_s;
        pad_s      = total_s - len_s;
        p_s        = (state_q == EMIT) ? pos_q + C_ONE : C_ZERO;
        didx_s     = total_s - C_ONE - p_s;
        ch_s       = 8'h20;
        if (left_q) begin
            didx_s = len_s - C_ONE - p_s;
            if (has_sign_s && p_s == C_ZERO) ch_s = sign_q;
            else if (p_s < len_s) ch_s = to_ascii(digit_of(ext_s, mode_q, int'(didx_s)));
            else ch_s = 8'h20;
        end else if (zpad_q) begin
            if (has_sign_s && p_s == C_ZERO) ch_s = sign_q;
            else if (p_s < pad_s + CW'(has_sign_s)) ch_s = 8'h30;
            else ch_s = to_ascii(digit_of(ext_s, mode_q, int'(didx_s)));
        end else begin
            if (p_s < pad_s) ch_s = 8'h20;
            else if (has_sign_s && p_s == pad_s) ch_s = sign_q;
            else ch_s = to_ascii(digit_of(ext_s, mode_q, int'(didx_s)));
        end
        last_s = (p_s == total_s - C_ONE);
    end

    // Next-state and output logic of the IDLE -> CONV -> EMIT sequencer.
    always_comb begin
        state_d     = state_q;
        val_d       = val_q;
        bcd_d       = bcd_q;
        bcd_t       = bcd_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        sign_d      = sign_q;
        width_d     = width_q;
        left_d      = left_q;
        zpad_d      = zpad_q;
        pos_d       = pos_q;
        out_valid_d = out_valid_q;
        out_char_d  = out_char_q;
        out_last_d  = out_last_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CONV;
                    val_d   = in_value;
                    bcd_d   = {NB{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    mode_d  = in_mode;
                    width_d = in_width;
                    left_d  = in_left;
                    zpad_d  = in_zpad;
                    pos_d   = C_ZERO;
                    // Negation as unsigned WIDTH bits maps the most negative value onto its own magnitude.
                    if (in_mode == MODE_DEC && in_signed && in_value[WIDTH-1]) begin
                        val_d  = -in_value;
                        sign_d = 8'h2D;
                    end else if (in_mode == MODE_DEC && in_plus) begin
                        sign_d = 8'h2B;
                    end else begin
                        sign_d = 8'h00;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                if (mode_q == MODE_DEC && cnt_q != CNT_W'(WIDTH)) begin
                    for (int k = 0; k < NDEC; k++) begin
                        if (bcd_t[4*k +: 4] >= 4'd5) bcd_t[4*k +: 4] = bcd_t[4*k +: 4] + 4'd3;
                        else bcd_t[4*k +: 4] = bcd_t[4*k +: 4];
                    end
                    bcd_d = {bcd_t[NB-2:0], val_q[WIDTH-1]};
                    val_d = {val_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d     = EMIT;
                    pos_d       = C_ZERO;
                    out_valid_d = 1'b1;
                    out_char_d  = ch_s;
                    out_last_d  = last_s;
                end
            end
            EMIT: begin
                if (out_ready && out_last_q) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_char_d  = 8'h00;
                    out_last_d  = 1'b0;
                end else if (out_ready) begin
                    pos_d      = p_s;
                    out_char_d = ch_s;
                    out_last_d = last_s;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_char_d  = 8'h00;
                out_last_d  = 1'b0;
            end
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            val_q       <= {WIDTH{1'b0}};
            bcd_q       <= {NB{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            mode_q      <= 2'b00;
            sign_q      <= 8'h00;
            width_q     <= {FW_W{1'b0}};
            left_q      <= 1'b0;
            zpad_q      <= 1'b0;
            pos_q       <= C_ZERO;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            val_q       <= val_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            sign_q      <= sign_d;
            width_q     <= width_d;
            left_q      <= left_d;
            zpad_q      <= zpad_d;
            pos_q       <= pos_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_fmt_num_ascii_stream.sv
// Bench for fmt_num_ascii_stream: directed fields plus randomized commands checked
// against a divide-and-remainder string model, with backpressure and mid-field reset.
module tb_fmt_num_ascii_stream;
    localparam int WIDTH = 32;
    localparam int FW_W  = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_value;
    logic [1:0]       in_mode;
    logic             in_signed, in_plus, in_left, in_zpad;
    logic [FW_W-1:0]  in_width;
    logic             out_valid, out_ready, out_last, busy;
    logic [7:0]       out_char;

    int  total = 0;
    int  bad   = 0;
    byte exp_q[$];

    always #5 clk = ~clk;

    fmt_num_ascii_stream #(.WIDTH(WIDTH), .FW_W(FW_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_mode(in_mode),
        .in_signed(in_signed), .in_plus(in_plus), .in_width(in_width),
        .in_left(in_left), .in_zpad(in_zpad),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
        .out_last(out_last), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic set_exp_str(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(byte'(s[i]));
    endtask

    // Reference: digits by repeated division, then sign/pad placement by the field rules.
    task automatic model(input logic [WIDTH-1:0] v, input logic [1:0] m, input bit sg, input bit pl,
                         input int w, input bit lf, input bit zp);
        longint unsigned mag;
        int  base, d, len, pad;
        byte sgn;
        byte digs[$];
        exp_q.delete();
        base = (m == 2'd0) ? 2 : (m == 2'd1) ? 8 : (m == 2'd2) ? 10 : 16;
        mag  = 64'(v);
        sgn  = 0;
        if (m == 2'd2 && sg && v[WIDTH-1]) begin
            mag = (64'd1 << WIDTH) - mag;
            sgn = 8'd45;
        end else if (m == 2'd2 && pl) begin
            sgn = 8'd43;
        end
        do begin
            d = int'(mag % 64'(base));
            digs.push_front((d < 10) ? 8'(48 + d) : 8'(87 + d));
            mag = mag / 64'(base);
        end while (mag != 0);
        len = digs.size() + ((sgn != 0) ? 1 : 0);
        pad = (w > len) ? w - len : 0;
        if (lf) begin
            if (sgn != 0) exp_q.push_back(sgn);
            foreach (digs[i]) exp_q.push_back(digs[i]);
            repeat (pad) exp_q.push_back(8'd32);
        end else if (zp) begin
            if (sgn != 0) exp_q.push_back(sgn);
            repeat (pad) exp_q.push_back(8'd48);
            foreach (digs[i]) exp_q.push_back(digs[i]);
        end else begin
            repeat (pad) exp_q.push_back(8'd32);
            if (sgn != 0) exp_q.push_back(sgn);
            foreach (digs[i]) exp_q.push_back(digs[i]);
        end
    endtask

    // Sends one command and consumes its field against exp_q; stop_at >= 0 resets mid-field.
    task automatic run(input string tag, input logic [WIDTH-1:0] v, input logic [1:0] m,
                       input bit sg, input bit pl, input int w, input bit lf, input bit zp,
                       input int rdy_mode, input int stop_at);
        int k, idx, guard, n;
        bit held, rdy;
        logic [7:0] hc;
        logic hl;
        n = exp_q.size();
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_value = v; in_mode = m; in_signed = sg; in_plus = pl;
        in_width = FW_W'(w); in_left = lf; in_zpad = zp;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            in_valid = 1'($urandom); in_value = WIDTH'($urandom); in_mode = 2'($urandom);
            in_signed = 1'($urandom); in_plus = 1'($urandom); in_width = FW_W'($urandom);
            in_left = 1'($urandom); in_zpad = 1'($urandom);
        end while (!out_valid && k < 200);
        check_eq({tag, "/latency"}, 64'(k), 64'((m == 2'd2) ? WIDTH + 2 : 2));
        idx = 0; guard = 0; held = 1'b0; hc = 8'h00; hl = 1'b0;
        while (idx < n && guard < 2000) begin
            if (idx == stop_at) begin
                in_valid = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                check_eq({tag, "/rst_valid"}, 64'(out_valid), 64'd0);
                check_eq({tag, "/rst_in_ready"}, 64'(in_ready), 64'd1);
                check_eq({tag, "/rst_busy"}, 64'(busy), 64'd0);
                check_eq({tag, "/rst_char"}, 64'(out_char), 64'h00);
                check_eq({tag, "/rst_last"}, 64'(out_last), 64'd0);
                rst_n = 1'b1;
                return;
            end
            check_eq({tag, "/valid"}, 64'(out_valid), 64'd1);
            check_eq({tag, "/in_ready_busy"}, 64'(in_ready), 64'd0);
            check_eq({tag, "/busy"}, 64'(busy), 64'd1);
            if (held) begin
                check_eq({tag, "/hold_char"}, 64'(out_char), 64'(hc));
                check_eq({tag, "/hold_last"}, 64'(out_last), 64'(hl));
            end
            case (rdy_mode)
                1:       rdy = (guard % 2 == 0);
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;
            if (rdy) begin
                check_eq({tag, "/char"}, 64'(out_char), 64'(8'(exp_q[idx])));
                check_eq({tag, "/last"}, 64'(out_last), 64'((idx == n - 1) ? 1 : 0));
                idx++;
                held = 1'b0;
            end else begin
                held = 1'b1; hc = out_char; hl = out_last;
            end
            in_valid = 1'($urandom);
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        check_eq({tag, "/count"}, 64'(idx), 64'(n));
        check_eq({tag, "/end_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "/end_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] rv;
        logic [1:0] rm;
        bit rsg, rpl, rlf, rzp;
        int rw;
        rst_n = 1'b0; in_valid = 1'b0; in_value = '0; in_mode = 2'b00; in_signed = 1'b0;
        in_plus = 1'b0; in_width = '0; in_left = 1'b0; in_zpad = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset/out_valid", 64'(out_valid), 64'd0);
        check_eq("reset/out_char", 64'(out_char), 64'h00);
        check_eq("reset/out_last", 64'(out_last), 64'd0);
        check_eq("reset/busy", 64'(busy), 64'd0);
        check_eq("reset/in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        set_exp_str("1000");           run("dec1000", 32'd1000, 2'd2, 0, 0, 0, 0, 0, 0, -1);
        set_exp_str("    -1");         run("dec_m1", 32'hFFFFFFFF, 2'd2, 1, 0, 6, 0, 0, 0, -1);
        set_exp_str("-2147483648");    run("dec_min", 32'h80000000, 2'd2, 1, 0, 0, 0, 0, 0, -1);
        set_exp_str("+0001000");       run("dec_plus_z", 32'd1000, 2'd2, 0, 1, 8, 0, 1, 0, -1);
        set_exp_str("+1000   ");       run("dec_plus_l", 32'd1000, 2'd2, 0, 1, 8, 1, 1, 0, -1);
        set_exp_str("000003e8");       run("hex_z", 32'h3E8, 2'd3, 0, 0, 8, 0, 1, 0, -1);
        set_exp_str("11");             run("oct9", 32'd9, 2'd1, 0, 0, 0, 0, 0, 0, -1);
        set_exp_str("0");              run("bin0", 32'd0, 2'd0, 0, 0, 0, 0, 0, 0, -1);
        set_exp_str("1001          "); run("bin9_l", 32'd9, 2'd0, 0, 0, 14, 1, 0, 0, -1);
        set_exp_str("deadbeef");       run("hex_trunc", 32'hDEADBEEF, 2'd3, 0, 0, 4, 0, 0, 0, -1);
        set_exp_str("1000");           run("dec_toggle", 32'd1000, 2'd2, 0, 0, 0, 0, 0, 1, -1);
        set_exp_str("1000");           run("dec_reset", 32'd1000, 2'd2, 0, 0, 0, 0, 0, 0, 2);
        set_exp_str("9");              run("hex9", 32'd9, 2'd3, 0, 0, 0, 0, 0, 0, -1);

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0:       rv = WIDTH'($urandom);
                1:       rv = WIDTH'($urandom) & 32'h000000FF;
                2:       rv = 32'h80000000 | (WIDTH'($urandom) & 32'h0000000F);
                default: rv = 32'hFFFFFFFF - (WIDTH'($urandom) & 32'h00000FFF);
            endcase
            rm  = 2'($urandom);
            rsg = 1'($urandom); rpl = 1'($urandom); rlf = 1'($urandom); rzp = 1'($urandom);
            rw  = $urandom_range(0, 36);
            model(rv, rm, rsg, rpl, rw, rlf, rzp);
            run("rand", rv, rm, rsg, rpl, rw, rlf, rzp, 2, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
